mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single SRAM-like memory port between the instruction-fetch master and the data-access master (load/store).
- Sits between the IF/MEM stages and the memory/bus bridge. Upstream and downstream both use req/addr_ok/data_ok semantics.
- Grants one address phase per cycle and locks the grant until it is accepted.
- Tracks outstanding transactions so that in-order data_ok responses return to the master that issued them.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (owner FIFO depth, >=1)
CNT_W, 2, width of the outstanding counter; must hold MAX_OUTSTANDING

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch data valid
inst_rdata  out  32  fetch data
data_req  in  1  data request
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  load data valid / store complete
data_rdata  out  32  load data
mem_req  out  1  request to memory
mem_wr  out  1  write
mem_size  out  2  size
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_addr_ok  in  1  memory accepted address
mem_data_ok  in  1  memory response (in order)
mem_rdata  in  32  memory read data

Behaviour:
- Reset (asynchronous, resetn=0):
  - outstanding count=0; FIFO pointers=0; lock=0; lock_owner=INST; rr_last=DATA.
  - All *_addr_ok, *_data_ok and mem_req are forced 0 while resetn=0.
- full = (count == MAX_OUTSTANDING).
- Owner selection, combinational, each cycle:
  - If lock=1: owner = lock_owner.
  - Else, if data_req=1: owner = DATA.
  - Else: owner = INST.
- mem_req = !full && (owner==DATA ? data_req : inst_req).
- Mux to the memory port:
  - mem_wr = data_wr when owner is DATA, else 0.
  - mem_size = data_size when owner is DATA, else 2.
  - mem_addr and mem_wdata come from the owner; mem_wdata = 0 for INST.
- Address-phase forwarding:
  - inst_addr_ok = mem_addr_ok && mem_req && owner==INST.
  - data_addr_ok is the same with owner==DATA.
- Lock:
  - Set lock=1 and lock_owner=owner when mem_req && !mem_addr_ok, so the address presented to memory never changes until accepted.
  - Clear lock on mem_addr_ok.
  - If the owner's req drops while locked (protocol violation), clear lock next cycle.
- Push: on mem_req && mem_addr_ok, write the owner id at the FIFO tail.
- Pop: on mem_data_ok with count>0, pop the head.
  - head==INST: inst_data_ok=1 and inst_rdata=mem_rdata.
  - head==DATA: same on the data_* side.
  - The non-head *_data_ok stays 0. Both rdata outputs carry mem_rdata unconditionally.
- Count update:
  - push only: +1; pop only: -1; push+pop in the same cycle: unchanged, FIFO still advances.
- Full: mem_req=0 even if a pop occurs in the same cycle (no bypass); the request issues the next cycle.
- mem_data_ok while count==0: ignored, no *_data_ok; simulation-only error message.
- Pointer wrap: pointers wrap modulo MAX_OUTSTANDING; non-power-of-2 depths use explicit compare-and-reset.
- Latency: zero added cycles. Address and response paths are combinational pass-through; only lock, FIFO and count are registered.
- Reset mid-transaction: all tracking is discarded. The memory side must also be reset, since stale responses are dropped.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when unlocked and both reqs are high, owner = the master not in rr_last. rr_last updates to the owner on every accepted address. Single-requester behaviour is unchanged.
- Undefined: fixed data-over-instruction priority as above; rr_last is not implemented.

Test Plan:
- Lone fetch: inst_req=1, addr 0xBFC00000, mem_addr_ok=1 in the same cycle, mem_data_ok 2 cycles later with rdata 0x24080001 -> inst_addr_ok=1 at cycle 0, inst_data_ok=1 with inst_rdata 0x24080001 at cycle 2, data_data_ok=0 throughout.
- Contention, fixed priority: inst_req and data_req both high, data load 0x80000010 -> mem_addr=0x80000010 and data_addr_ok first; the fetch is granted the next cycle.
- Lock hold: data_req asserted, mem_addr_ok=0 for 3 cycles, inst_req rises at cycle 1 -> mem_addr stays the data address for all 3 cycles; inst_addr_ok=0 until the data address is accepted.
- Ordering: issue INST then DATA (store, size 0, wdata 0x000000AB); memory returns two data_ok -> first goes to inst_data_ok, second to data_data_ok; mem_wr=1 and mem_size=0 on the store address phase.
- Full/simultaneous: MAX_OUTSTANDING=2, two accepted fetches with no response -> mem_req=0. A pop in the same cycle as a pending inst_req -> no grant that cycle, grant the next; count goes 2->1->2.
- Reset mid-flight: one outstanding, assert resetn=0 asynchronously -> mem_req and all *_ok low immediately; after release, count=0 and a stray mem_data_ok produces no *_data_ok.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch master
//   (inst_*) and the data master (data_*). It grants one address phase per
//   cycle and holds that grant until memory accepts the address. A small
//   owner FIFO records which master issued each accepted address, so that
//   in-order mem_data_ok responses go back to the right master.
//
//   Handshake (all three sides): a master holds *_req high with stable
//   addr/wr/size/wdata until *_addr_ok is seen high in the same cycle; that
//   cycle is the accepted address phase. Each accepted address later gets
//   exactly one *_data_ok pulse, in issue order, carrying read data for
//   loads or completion for stores.
//
//   Ports:
//     clk, resetn                 clock, asynchronous active-low reset
//     inst_req/addr               fetch request and address
//     inst_addr_ok/data_ok/rdata  fetch accept, response valid, read data
//     data_req/wr/size/addr/wdata data-master request (size 0=B,1=H,2=W)
//     data_addr_ok/data_ok/rdata  data accept, response valid, read data
//     mem_req/wr/size/addr/wdata  request towards memory
//     mem_addr_ok/data_ok/rdata   memory accept, in-order response, data
//
//   Parameters:
//     MAX_OUTSTANDING  accepted-but-unanswered transactions (>=1)
//     CNT_W            outstanding counter width, must hold MAX_OUTSTANDING
//
//   Build option:
//     MEM_ARB_ROUND_ROBIN_EN  when defined, simultaneous unlocked requests
//                             alternate between masters; otherwise the data
//                             master always wins.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int                PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    logic                       r_lock;
    logic                       r_lock_owner;
    logic [CNT_W-1:0]           r_count;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [MAX_OUTSTANDING-1:0] r_owner_fifo;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                       r_rr_last;
`endif

    logic w_full;
    logic w_owner;
    logic w_owner_req;
    logic w_mem_req;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Explicit compare-and-reset so non-power-of-2 depths wrap correctly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full = (r_count == CNT_MAX);

    always_comb begin
        w_owner = OWN_INST;
        if (r_lock) begin
            w_owner = r_lock_owner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        end else if (data_req && inst_req) begin
            w_owner = (r_rr_last == OWN_DATA) ? OWN_INST : OWN_DATA;
`endif
        end else if (data_req) begin
            w_owner = OWN_DATA;
        end else begin
            w_owner = OWN_INST;
        end
    end

    assign w_owner_req = (w_owner == OWN_DATA) ? data_req : inst_req;
    // resetn gates every handshake output combinationally so they drop
    // the moment reset is asserted, not at the next edge.
    assign w_mem_req   = resetn && !w_full && w_owner_req;
    assign w_push      = w_mem_req && mem_addr_ok;
    // A response with nothing outstanding is stale and is dropped.
    assign w_pop       = resetn && mem_data_ok && (r_count != '0);
    assign w_head      = r_owner_fifo[r_rd_ptr];

    assign mem_req   = w_mem_req;
    assign mem_wr    = (w_owner == OWN_DATA) ? data_wr    : 1'b0;
    assign mem_size  = (w_owner == OWN_DATA) ? data_size  : 2'd2;
    assign mem_addr  = (w_owner == OWN_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (w_owner == OWN_DATA) ? data_wdata : 32'd0;

    assign inst_addr_ok = mem_addr_ok && w_mem_req && (w_owner == OWN_INST);
    assign data_addr_ok = mem_addr_ok && w_mem_req && (w_owner == OWN_DATA);
    assign inst_data_ok = w_pop && (w_head == OWN_INST);
    assign data_data_ok = w_pop && (w_head == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_INST;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_owner_fifo <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rr_last    <= OWN_DATA;
`endif
        end else begin
            // Lock keeps the presented address stable until accepted; a
            // master that withdraws its request releases the lock.
            if (w_push) begin
                r_lock <= 1'b0;
            end else if (w_mem_req) begin
                r_lock       <= 1'b1;
                r_lock_owner <= w_owner;
            end else if (r_lock && !w_owner_req) begin
                r_lock <= 1'b0;
            end

            if (w_push) begin
                r_owner_fifo[r_wr_ptr] <= w_owner;
                r_wr_ptr               <= ptr_next(r_wr_ptr);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                r_rr_last              <= w_owner;
`endif
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && mem_data_ok && (r_count == '0)) begin
            $warning("mem_port_arbiter: mem_data_ok with no outstanding transaction ignored");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default build: fixed priority,
// MAX_OUTSTANDING=2). Inputs change 1 time unit after the rising edge;
// outputs are checked 2 units later, well before the falling edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    // Scoreboard: owner of each accepted address (0=INST, 1=DATA), in order.
    logic [0:0] exp_q[$];

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wdata  = 32'd0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One response cycle; expected routing comes from the scoreboard.
    task automatic respond(input string tag, input logic [31:0] rd);
        logic has;
        logic own;
        has = (exp_q.size() > 0);
        own = 1'b0;
        if (has) own = exp_q.pop_front();
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        settle();
        chk({tag, "_inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, has && !own});
        chk({tag, "_data_data_ok"}, {31'd0, data_data_ok}, {31'd0, has && own});
        if (has && !own) chk({tag, "_inst_rdata"}, inst_rdata, rd);
        if (has && own)  chk({tag, "_data_rdata"}, data_rdata, rd);
        tick();
        mem_data_ok = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        inst_addr = 32'd0;
        data_addr = 32'd0;
        resetn    = 1'b0;
        tick();

        // Reset: outputs forced low even with every input active.
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        settle();
        chk("rst_mem_req",      {31'd0, mem_req},      32'd0);
        chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        chk("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        tick();
        idle();
        resetn = 1'b1;
        tick();

        // Lone fetch, accepted immediately, answered two cycles later.
        inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
        settle();
        chk("f_mem_req",      {31'd0, mem_req},      32'd1);
        chk("f_mem_addr",     mem_addr,              32'hBFC00000);
        chk("f_mem_size",     {30'd0, mem_size},     32'd2);
        chk("f_mem_wr",       {31'd0, mem_wr},       32'd0);
        chk("f_mem_wdata",    mem_wdata,             32'd0);
        chk("f_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        chk("f_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        exp_q.push_back(1'b0);
        tick();
        idle();
        settle();
        chk("f_c1_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        chk("f_c1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        tick();
        respond("f_c2", 32'h24080001);

        // Contention: data wins, fetch granted the next cycle.
        inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80000010;
        mem_addr_ok = 1'b1;
        settle();
        chk("c_mem_addr",     mem_addr,              32'h80000010);
        chk("c_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("c_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        exp_q.push_back(1'b1);
        tick();
        data_req = 1'b0;
        settle();
        chk("c1_mem_addr",     mem_addr,              32'hBFC00004);
        chk("c1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(1'b0);
        tick();
        idle();
        respond("c_r0", 32'h11111111);
        respond("c_r1", 32'h22222222);

        // Lock hold on a data address; fetch arrives while it waits.
        data_req = 1'b1; data_addr = 32'h80000020; mem_addr_ok = 1'b0;
        settle();
        chk("ld0_mem_req",      {31'd0, mem_req},      32'd1);
        chk("ld0_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC00008;
        for (int i = 1; i < 3; i++) begin
            settle();
            chk("ld_mem_addr",     mem_addr,              32'h80000020);
            chk("ld_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
            tick();
        end
        mem_addr_ok = 1'b1;
        settle();
        chk("ld3_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("ld3_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        exp_q.push_back(1'b1);
        tick();
        data_req = 1'b0;
        settle();
        chk("ld4_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        chk("ld4_mem_addr",     mem_addr,              32'hBFC00008);
        exp_q.push_back(1'b0);
        tick();
        idle();
        respond("ld_r0", 32'h33333333);
        respond("ld_r1", 32'h44444444);

        // Lock hold on a fetch: a later data request must not steal the port.
        inst_req = 1'b1; inst_addr = 32'hBFC0000C; mem_addr_ok = 1'b0;
        settle();
        chk("li0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
        data_addr = 32'h80000030; data_wdata = 32'h0000BEEF;
        settle();
        chk("li1_mem_addr",     mem_addr,              32'hBFC0000C);
        chk("li1_mem_wr",       {31'd0, mem_wr},       32'd0);
        chk("li1_mem_wdata",    mem_wdata,             32'd0);
        chk("li1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("li2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        chk("li2_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        exp_q.push_back(1'b0);
        tick();
        inst_req = 1'b0;
        settle();
        chk("li3_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("li3_mem_size",     {30'd0, mem_size},     32'd1);
        exp_q.push_back(1'b1);
        tick();
        idle();
        respond("li_r0", 32'h55555555);
        respond("li_r1", 32'h00000000);

        // Locked master withdraws: no request that cycle, lock released next.
        data_req = 1'b1; data_addr = 32'h80000040; mem_addr_ok = 1'b0;
        tick();
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00020;
        settle();
        chk("wd0_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("wd1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        chk("wd1_mem_addr",     mem_addr,              32'hBFC00020);
        exp_q.push_back(1'b0);
        tick();
        idle();
        respond("wd_r0", 32'h66666666);

        // Ordering: fetch then byte store; responses routed in issue order.
        inst_req = 1'b1; inst_addr = 32'hBFC00010; mem_addr_ok = 1'b1;
        settle();
        chk("o0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(1'b0);
        tick();
        inst_req = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h80000041; data_wdata = 32'h000000AB;
        settle();
        chk("o1_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("o1_mem_wr",       {31'd0, mem_wr},       32'd1);
        chk("o1_mem_size",     {30'd0, mem_size},     32'd0);
        chk("o1_mem_wdata",    mem_wdata,             32'h000000AB);
        chk("o1_mem_addr",     mem_addr,              32'h80000041);
        exp_q.push_back(1'b1);
        tick();
        idle();
        respond("o_r0", 32'h77777777);
        respond("o_r1", 32'h00000000);

        // Full: two fetches outstanding block a third, even on a pop cycle.
        inst_req = 1'b1; inst_addr = 32'hBFC000A0; mem_addr_ok = 1'b1;
        tick();
        exp_q.push_back(1'b0);
        inst_addr = 32'hBFC000A4;
        tick();
        exp_q.push_back(1'b0);
        inst_addr = 32'hBFC000A8;
        settle();
        chk("full0_mem_req",      {31'd0, mem_req},      32'd0);
        chk("full0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h88888888;
        void'(exp_q.pop_front());
        settle();
        chk("full1_mem_req",      {31'd0, mem_req},      32'd0);
        chk("full1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        chk("full1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("full1_inst_rdata",   inst_rdata,            32'h88888888);
        tick();
        mem_data_ok = 1'b0;
        settle();
        chk("full2_mem_req",      {31'd0, mem_req},      32'd1);
        chk("full2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(1'b0);
        tick();
        inst_addr = 32'hBFC000AC;
        settle();
        chk("full3_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        idle();
        respond("full_r0", 32'h99999999);
        respond("full_r1", 32'hAAAAAAAA);

        // Reset mid-flight: one outstanding, reset asserted between edges.
        inst_req = 1'b1; inst_addr = 32'hBFC000B0; mem_addr_ok = 1'b1;
        settle();
        chk("rm0_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'hBBBBBBBB;
        #1;
        resetn = 1'b0;
        #1;
        chk("rm1_mem_req",      {31'd0, mem_req},      32'd0);
        chk("rm1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        chk("rm1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        chk("rm1_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        chk("rm1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        exp_q.delete();
        tick();
        idle();
        resetn = 1'b1;
        tick();
        respond("rm_stray", 32'hCCCCCCCC);
        inst_req = 1'b1; inst_addr = 32'hBFC000B4; mem_addr_ok = 1'b1;
        settle();
        chk("rm2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(1'b0);
        tick();
        idle();
        respond("rm_r0", 32'hDDDDDDDD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #20000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
